// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory access controller.
package imem_pkg;

   // Controller sequencing: boot-load, one-cycle drain, then run.
   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_RUN   = 2'd2
   } imem_state_e;

   localparam logic [31:0] IMEM_NOP_INST = 32'h0000_0013;
   localparam int unsigned IMEM_WORD_AW  = 18;

   // Word accesses are only legal on 4-byte boundaries.
   function automatic logic imem_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/imem_rr_starve_arb.sv
// Fetch/debug arbiter for the shared read port. Fetch wins by default; a
// pending debug request is forced through after MAX_WAIT consecutive denials.
module imem_rr_starve_arb #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic if_req_i,
   input  logic dbg_req_i,
   output logic if_gnt_o,
   output logic dbg_gnt_o
);

   localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [CW-1:0] wait_q, wait_d;
   logic          starved;

   // Per-cycle grant decision and next value of the denial counter.
   always_comb begin
      starved   = (wait_q == CW'(MAX_WAIT));
      dbg_gnt_o = en_i & dbg_req_i & (~if_req_i | starved);
      if_gnt_o  = en_i & if_req_i & ~dbg_gnt_o;
      wait_d    = '0;
      if (en_i && dbg_req_i && !dbg_gnt_o) begin
         wait_d = wait_q + CW'(1);
      end
   end

   // Denial counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

endmodule

// File: rtl/imem_access_ctrl.sv
// Instruction-memory port owner: boot-loads the image over a valid/ready
// stream, then shares the read port between core fetch and a debug reader.
module imem_access_ctrl
   import imem_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           WORD_AW    = IMEM_WORD_AW,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           MAX_WAIT   = 4,
   parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(IMEM_NOP_INST)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  ld_last,
   output logic [7:0]            ld_err_cnt,
   output logic                  core_run,
   input  logic [ADDR_WIDTH-1:0] if_pc,
   input  logic                  if_req,
   output logic                  if_gnt,
   output logic [DATA_WIDTH-1:0] if_inst,
   output logic                  if_fault,
   input  logic                  dbg_req,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic                  dbg_gnt,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic [WORD_AW-1:0]    mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   imem_state_e      state_q, state_d;
   logic             core_run_q, core_run_d;
   logic [7:0]       err_q, err_d;

   logic             run_en;
   logic             fetch_gnt, debug_gnt;
   logic [WORD_AW-1:0] ld_idx, pc_idx, dbg_idx;
   logic             ld_aligned, pc_aligned;
   logic             unused_addr_bits;

   // Byte addresses reduce to word indices; upper bits alias away.
   always_comb begin
      ld_idx     = ld_addr[WORD_AW+1:2];
      pc_idx     = if_pc[WORD_AW+1:2];
      dbg_idx    = dbg_addr[WORD_AW+1:2];
      ld_aligned = imem_aligned(ld_addr[1:0]);
      pc_aligned = imem_aligned(if_pc[1:0]);
      run_en     = (state_q == ST_RUN);
      unused_addr_bits = ^{ld_addr[ADDR_WIDTH-1:WORD_AW+2],
                           if_pc[ADDR_WIDTH-1:WORD_AW+2],
                           dbg_addr[ADDR_WIDTH-1:WORD_AW+2],
                           dbg_addr[1:0]};
   end

   imem_rr_starve_arb #(
      .MAX_WAIT (MAX_WAIT)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (run_en),
      .if_req_i  (if_req),
      .dbg_req_i (dbg_req),
      .if_gnt_o  (fetch_gnt),
      .dbg_gnt_o (debug_gnt)
   );

   // Next-state, loader handshake, error count and memory port steering.
   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      core_run_d = core_run_q | (state_q == ST_DRAIN);
      ld_ready   = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = ld_idx;
      mem_wdata  = ld_data;
      case (state_q)
         ST_LOAD: begin
            ld_ready = 1'b1;
            if (ld_valid) begin
               if (ld_aligned) begin
                  mem_we = 1'b1;
               end else if (err_q != 8'hFF) begin
                  err_d = err_q + 8'd1;
               end
               if (ld_last) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            mem_addr = debug_gnt ? dbg_idx : pc_idx;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // Fetch and debug return paths; faulted or idle fetches see the NOP word.
   always_comb begin
      if_gnt    = fetch_gnt;
      dbg_gnt   = debug_gnt;
      if_inst   = NOP_INST;
      if_fault  = 1'b0;
      dbg_rdata = '0;
      if (fetch_gnt) begin
         if (pc_aligned) begin
            if_inst = mem_rdata;
         end else begin
            if_fault = 1'b1;
         end
      end
      if (debug_gnt) begin
         dbg_rdata = mem_rdata;
      end
   end

   // Controller state, core release flag and loader error counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_LOAD;
         core_run_q <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         core_run_q <= core_run_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      core_run   = core_run_q;
      ld_err_cnt = err_q;
   end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Self-checking bench for imem_access_ctrl: table-driven boot load, directed
// drain/run corner cases, then randomized fetch/debug traffic vs. a model.
module tb_imem_access_ctrl;

   localparam int unsigned AW  = 32;
   localparam int unsigned WAW = 18;
   localparam int unsigned DW  = 32;
   localparam int unsigned MW  = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           ld_valid = 1'b0, ld_ready, ld_last = 1'b0;
   logic [AW-1:0]  ld_addr = '0;
   logic [DW-1:0]  ld_data = '0;
   logic [7:0]     ld_err_cnt;
   logic           core_run;
   logic [AW-1:0]  if_pc = '0;
   logic           if_req = 1'b0, if_gnt, if_fault;
   logic [DW-1:0]  if_inst;
   logic           dbg_req = 1'b0, dbg_gnt;
   logic [AW-1:0]  dbg_addr = '0;
   logic [DW-1:0]  dbg_rdata;
   logic [WAW-1:0] mem_addr;
   logic           mem_we;
   logic [DW-1:0]  mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   imem_access_ctrl #(
      .ADDR_WIDTH (AW),
      .WORD_AW    (WAW),
      .DATA_WIDTH (DW),
      .MAX_WAIT   (MW),
      .NOP_INST   (NOP)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .ld_valid (ld_valid), .ld_ready (ld_ready), .ld_addr (ld_addr),
      .ld_data (ld_data), .ld_last (ld_last), .ld_err_cnt (ld_err_cnt),
      .core_run (core_run),
      .if_pc (if_pc), .if_req (if_req), .if_gnt (if_gnt),
      .if_inst (if_inst), .if_fault (if_fault),
      .dbg_req (dbg_req), .dbg_addr (dbg_addr), .dbg_gnt (dbg_gnt),
      .dbg_rdata (dbg_rdata),
      .mem_addr (mem_addr), .mem_we (mem_we), .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Memory array environment: combinational read, synchronous write.
   logic [DW-1:0] mem_arr [0:(1<<WAW)-1];
   assign mem_rdata = mem_arr[mem_addr];
   always @(posedge clk) if (mem_we) mem_arr[mem_addr] <= mem_wdata;

   // Reference image: word index -> expected contents.
   logic [DW-1:0] img [int unsigned];
   int unsigned   loaded_q [$];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int unsigned widx(input logic [AW-1:0] a);
      return (a / 4) % (1 << WAW);
   endfunction

   function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
      int unsigned k = widx(a);
      return img.exists(k) ? img[k] : '0;
   endfunction

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          exp_we;
      int unsigned   exp_idx;
      logic [7:0]    exp_err;
   } ld_vec_t;

   ld_vec_t vecs [6];

   // One loader beat in LOAD: checks write strobe now, error count after the edge.
   task automatic load_beat(input ld_vec_t v, input string tag);
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = v.addr; ld_data = v.data; ld_last = 1'b0;
      #1;
      chk({tag, "_we"}, mem_we, v.exp_we);
      chk({tag, "_ready"}, ld_ready, 1'b1);
      if (v.exp_we) begin
         chk({tag, "_maddr"}, mem_addr, v.exp_idx);
         chk({tag, "_wdata"}, mem_wdata, v.data);
         img[v.exp_idx] = v.data;
         loaded_q.push_back(v.exp_idx * 4);
      end
      @(posedge clk); #1;
      ld_valid = 1'b0;
      chk({tag, "_err"}, ld_err_cnt, v.exp_err);
   endtask

   int denied = 0;

   // One RUN cycle against the arbitration/alignment model.
   task automatic run_cycle(input logic fr, input logic [AW-1:0] pc,
                            input logic dr, input logic [AW-1:0] da);
      logic e_dbg, e_if, e_flt;
      logic [DW-1:0] e_inst;
      @(negedge clk);
      if_req = fr; if_pc = pc; dbg_req = dr; dbg_addr = da;
      #1;
      e_dbg  = dr && (!fr || denied == MW);
      e_if   = fr && !e_dbg;
      e_flt  = e_if && (pc % 4 != 0);
      e_inst = (e_if && !e_flt) ? word_at(pc) : NOP;
      chk("run_dbg_gnt", dbg_gnt, e_dbg);
      chk("run_if_gnt", if_gnt, e_if);
      chk("run_if_fault", if_fault, e_flt);
      chk("run_if_inst", if_inst, e_inst);
      if (e_dbg) chk("run_dbg_rdata", dbg_rdata, word_at(da));
      chk("run_mem_we", mem_we, 1'b0);
      chk("run_ld_ready", ld_ready, 1'b0);
      denied = (dr && !e_dbg) ? denied + 1 : 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic pend;
      logic [AW-1:0] pa;
      ld_vec_t v;
      for (int unsigned i = 0; i < (1 << WAW); i++) mem_arr[i] = '0;

      // Reset state.
      #12;
      chk("rst_core_run", core_run, 1'b0);
      chk("rst_ld_ready", ld_ready, 1'b1);
      chk("rst_err", ld_err_cnt, 8'd0);
      chk("rst_mem_we", mem_we, 1'b0);
      @(negedge clk); rst_n = 1'b1;

      // Partial load, then asynchronous reset mid-burst.
      v = '{32'h40, 32'hDEAD_0000, 1'b1, 16, 8'd0}; load_beat(v, "pre0");
      v = '{32'h41, 32'hDEAD_0001, 1'b0, 0, 8'd1};  load_beat(v, "pre1");
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 32'h44; ld_data = 32'hBAD0_BAD0;
      #2; ld_valid = 1'b0; rst_n = 1'b0;
      #1;
      chk("midrst_core_run", core_run, 1'b0);
      chk("midrst_ld_ready", ld_ready, 1'b1);
      chk("midrst_err", ld_err_cnt, 8'd0);
      @(negedge clk); rst_n = 1'b1;

      // Reload: table-driven beats.
      vecs[0] = '{32'h0000_0006, 32'h9999_9999, 1'b0, 0, 8'd1};
      vecs[1] = '{32'h0000_0000, 32'h1111_1111, 1'b1, 0, 8'd1};
      vecs[2] = '{32'h0000_0008, 32'h3333_3333, 1'b1, 2, 8'd1};
      vecs[3] = '{32'h0010_0010, 32'h4444_4444, 1'b1, 4, 8'd1};
      vecs[4] = '{32'hFFFF_FFFD, 32'h5A5A_5A5A, 1'b0, 0, 8'd2};
      vecs[5] = '{32'h0000_0200, 32'h5555_5555, 1'b1, 128, 8'd2};
      for (int i = 0; i < 6; i++) load_beat(vecs[i], $sformatf("tbl%0d", i));

      // Random aligned words, including aliased upper bits.
      for (int i = 0; i < 16; i++) begin
         int unsigned k = $urandom_range(200, 4000);
         v = '{(32'(k) << 2) | (32'($urandom_range(0, 4095)) << 20),
               $urandom, 1'b1, k, 8'd2};
         load_beat(v, "rnd_ld");
      end

      // 300 misaligned words: counter saturates at 255.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         ld_valid = 1'b1; ld_addr = ($urandom & ~32'h3) | 32'($urandom_range(1, 3));
         ld_data = $urandom; ld_last = 1'b0;
         #1;
         if (mem_we !== 1'b0) chk("sat_we", mem_we, 1'b0);
      end
      @(negedge clk); ld_valid = 1'b0;
      chk("sat_err", ld_err_cnt, 8'd255);

      // Last word coinciding with a fetch request.
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 32'h4; ld_data = 32'h2222_2222; ld_last = 1'b1;
      if_req = 1'b1; if_pc = 32'h4;
      #1;
      chk("last_we", mem_we, 1'b1);
      chk("last_if_gnt", if_gnt, 1'b0);
      chk("last_if_inst", if_inst, NOP);
      chk("last_core_run", core_run, 1'b0);
      img[1] = 32'h2222_2222; loaded_q.push_back(4);
      @(posedge clk); #1;
      ld_addr = 32'h300; ld_data = 32'hBEEF_BEEF; ld_last = 1'b0;
      #1;
      chk("drain_ready", ld_ready, 1'b0);
      chk("drain_we", mem_we, 1'b0);
      chk("drain_if_gnt", if_gnt, 1'b0);
      chk("drain_core_run", core_run, 1'b0);
      @(posedge clk); #1;
      chk("run_core_run", core_run, 1'b1);
      chk("run_fetch_gnt", if_gnt, 1'b1);
      chk("run_fetch_inst", if_inst, 32'h2222_2222);
      chk("run_ld_ignored", mem_we, 1'b0);
      ld_valid = 1'b0;

      // Directed RUN cases.
      run_cycle(1'b1, 32'h2, 1'b0, '0);
      chk("flt_fault", if_fault, 1'b1);
      chk("flt_inst", if_inst, NOP);
      run_cycle(1'b0, '0, 1'b1, 32'h8);
      chk("dbg_idle_gnt", dbg_gnt, 1'b1);
      chk("dbg_idle_data", dbg_rdata, 32'h3333_3333);
      run_cycle(1'b0, '0, 1'b1, 32'h5);
      chk("dbg_misal_data", dbg_rdata, 32'h2222_2222);
      chk("dbg_misal_nofault", if_fault, 1'b0);
      run_cycle(1'b1, 32'h0010_0008, 1'b0, '0);
      chk("fetch_alias", if_inst, 32'h3333_3333);
      for (int i = 0; i < 5; i++) begin
         run_cycle(1'b1, 32'h8, 1'b1, 32'h0);
         chk($sformatf("starve_dbg%0d", i), dbg_gnt, (i == 4));
         chk($sformatf("starve_if%0d", i), if_gnt, (i != 4));
         if (i == 4) chk("starve_rdata", dbg_rdata, 32'h1111_1111);
      end
      run_cycle(1'b1, 32'h8, 1'b0, '0);
      chk("starve_after_if", if_gnt, 1'b1);

      // Randomized traffic; debug requests held until granted.
      pend = 1'b0; pa = '0;
      for (int i = 0; i < 2000; i++) begin
         logic [AW-1:0] pc;
         pc = loaded_q[$urandom_range(0, loaded_q.size() - 1)];
         if ($urandom_range(0, 7) == 0) pc = pc | 32'($urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0) pc = pc | (32'($urandom_range(1, 4095)) << 20);
         if (!pend && $urandom_range(0, 2) == 0) begin
            pend = 1'b1;
            pa = loaded_q[$urandom_range(0, loaded_q.size() - 1)] | 32'($urandom_range(0, 3));
         end
         ld_valid = $urandom_range(0, 1);
         ld_addr = '0;
         run_cycle($urandom_range(0, 3) != 0, pc, pend, pa);
         if (dbg_gnt) pend = 1'b0;
      end
      chk("final_err", ld_err_cnt, 8'd255);
      chk("final_core_run", core_run, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Owns the single instruction-memory port and sequences it through boot-load then run.
- Boot: a program loader streams words into the memory over a valid/ready handshake; the core is held.
- Run: the core fetch path and a debug read port share the read port. Fetch has priority; the debug port has a bounded-wait anti-starvation rule.
- Sits between the core's fetch stage, the loader/debug host interface, and the instruction memory array.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the PC, loader and debug addresses
- WORD_AW, 18, word-index width driven to memory (word index = addr[WORD_AW+1:2])
- DATA_WIDTH, 32, instruction word width
- MAX_WAIT, 4, maximum consecutive cycles the debug port may be denied in RUN
- NOP_INST, 32'h00000013, word returned on a faulted fetch

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_valid  in  1  loader word valid
- ld_ready  out  1  controller accepts a loader word
- ld_addr  in  ADDR_WIDTH  loader byte address
- ld_data  in  DATA_WIDTH  loader word
- ld_last  in  1  final word of the program image
- ld_err_cnt  out  8  count of dropped misaligned loader words, saturating
- core_run  out  1  core released from hold
- if_pc  in  ADDR_WIDTH  fetch byte address
- if_req  in  1  fetch request
- if_gnt  out  1  fetch served this cycle
- if_inst  out  DATA_WIDTH  fetched instruction
- if_fault  out  1  misaligned fetch
- dbg_req  in  1  debug read request, held until granted
- dbg_addr  in  ADDR_WIDTH  debug byte address
- dbg_gnt  out  1  debug read served this cycle
- dbg_rdata  out  DATA_WIDTH  debug read data
- mem_addr  out  WORD_AW  word index to memory
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, combinational from mem_addr

Behaviour:
- States: LOAD, DRAIN, RUN. Reset sets the state to LOAD.
- Reset values: core_run=0, ld_err_cnt=0, wait counter=0, mem_we=0. Reset is asynchronous; a reset mid-load abandons the image and returns to LOAD.
- LOAD:
  - ld_ready=1. A word is accepted when ld_valid && ld_ready.
  - Aligned address (addr[1:0]==0): mem_we=1 in the acceptance cycle, with mem_addr=ld_addr[WORD_AW+1:2] and mem_wdata=ld_data.
  - Misaligned address: no write; ld_err_cnt increments and saturates at 255.
  - Accepted word with ld_last=1 (aligned or not): go to DRAIN.
  - if_gnt=0, dbg_gnt=0, if_inst=NOP_INST.
- DRAIN:
  - One cycle. ld_ready=0, mem_we=0, no grants. Then go to RUN.
  - core_run rises on entry to RUN (registered) and stays 1 until reset.
- RUN:
  - ld_ready=0, mem_we=0 permanently; further loader traffic is ignored.
  - Arbitration is combinational per cycle.
  - Default: if if_req=1, fetch owns the port: mem_addr from if_pc, if_gnt=1, dbg_gnt=0.
  - If dbg_req=1 and (if_req=0 or the wait counter == MAX_WAIT): debug owns the port: dbg_gnt=1, if_gnt=0, core stalls.
  - Wait counter: increments each cycle dbg_req=1 and debug is denied; clears on dbg_gnt or when dbg_req=0.
- Fetch alignment:
  - Granted fetch with if_pc[1:0]!=0: if_fault=1, if_inst=NOP_INST, memory data ignored.
  - Otherwise if_fault=0 and if_inst=mem_rdata when if_gnt=1, else NOP_INST.
- Debug alignment: a misaligned dbg_addr is granted normally and returns mem_rdata of the truncated word index, with no fault.
- Address wrap: upper address bits above WORD_AW+1 are ignored, so addresses alias modulo 2^(WORD_AW+2).
- Simultaneous ld_last acceptance and a fetch request: the fetch is not served; the core only fetches once core_run=1.

Decomposition:
- Shared package imem_pkg: state encoding (LOAD/DRAIN/RUN), NOP_INST, default WORD_AW.
- One natural sub-module: imem_rr_starve_arb, holding the fetch/debug arbiter and its wait counter.

Test Plan:
- Load words 0x11111111, 0x22222222 at 0x0 and 0x4, ld_last on the second, then fetch pc=0x4 -> mem_we pulses twice; core_run=1 two cycles after the last accept; if_inst=0x22222222, if_gnt=1.
- Load at ld_addr=0x6 -> no mem_we; ld_err_cnt=1. Then load 300 misaligned words -> ld_err_cnt saturates at 255.
- RUN, fetch if_pc=0x2 -> if_fault=1, if_inst=0x00000013.
- RUN, if_req held at 1, dbg_req=1 at 0x0 -> dbg_gnt=1 on the 5th cycle (MAX_WAIT=4 denials), if_gnt=0 that cycle only, dbg_rdata=0x11111111.
- Drop rst_n during a load burst -> core_run=0 and ld_ready=1 immediately; a reload then works.
- if_req=0, dbg_req=1 -> dbg_gnt=1 the same cycle, with zero wait.
